// File: rtl/npu_pkg.sv
// Shared NPU definitions: flattened-vector geometry and the streamer state type.
package npu_pkg;

    localparam int unsigned NPU_FLAT_LEN = 225;
    localparam int unsigned NPU_ACC_W    = 22;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } stream_state_t;

endpackage

// File: rtl/flatten_streamer.sv
// Streams a held flattened vector one element per valid/ready transfer, then pulses o_done.
// Optional running checksum output enabled by defining FLATTEN_STREAMER_CHECKSUM_EN.
module flatten_streamer
    import npu_pkg::*;
#(
    parameter int unsigned N_ELEM = NPU_FLAT_LEN,
    parameter int unsigned DATA_W = NPU_ACC_W,
    parameter int unsigned IDX_W  = $clog2(N_ELEM)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic [N_ELEM*DATA_W-1:0]   i_vector,
    input  logic                       i_ready,
    output logic                       o_valid,
    output logic signed [DATA_W-1:0]   o_data,
    output logic [IDX_W-1:0]           o_index,
    output logic                       o_last,
    output logic                       o_busy,
`ifdef FLATTEN_STREAMER_CHECKSUM_EN
    output logic signed [DATA_W+8-1:0] o_checksum,
`endif
    output logic                       o_done
);

    localparam int unsigned CSUM_W   = DATA_W + 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    stream_state_t    state;
    logic [IDX_W-1:0] index;
    logic             at_last;
    logic             xfer;

    assign at_last = (index == LAST_IDX);
    assign xfer    = (state == ST_STREAM) && i_ready;

    // Control FSM; index only advances on an accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            index <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        index <= '0;
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (i_ready) begin
                        if (at_last) begin
                            state <= ST_DONE;
                        end else begin
                            index <= index + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Element mux straight off the index register; upstream holds i_vector until o_done.
    always_comb begin
        o_data = '0;
        if (state == ST_STREAM) begin
            o_data = i_vector[index*DATA_W +: DATA_W];
        end
    end

    assign o_valid = (state == ST_STREAM);
    assign o_index = (state == ST_STREAM) ? index : '0;
    assign o_last  = (state == ST_STREAM) && at_last;
    assign o_busy  = (state != ST_IDLE);
    assign o_done  = (state == ST_DONE);

`ifdef FLATTEN_STREAMER_CHECKSUM_EN
    // Running sum of accepted elements; holds its final value until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_checksum <= '0;
        end else if ((state == ST_IDLE) && i_start) begin
            o_checksum <= '0;
        end else if (xfer) begin
            o_checksum <= o_checksum + CSUM_W'(o_data);
        end
    end
`endif

endmodule
